// File: rtl/nibble_serial_add_sub_pkg.sv
// Shared types for the nibble-serial add/subtract engine: slice width,
// controller states and the result flag bundle.
package addsub_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   typedef struct packed {
      logic c;
      logic v;
      logic z;
      logic n;
   } flag_t;

endpackage

// File: rtl/nibble_serial_add_sub_if.sv
// Request/response bundle of the nibble-serial add/subtract engine; the
// requester uses the master view, the engine the slave view.
interface nibble_serial_add_sub_if #(
   parameter int NIBBLES = 4
);
   localparam int W = addsub_pkg::NIBBLE_W * NIBBLES;

   logic         in_valid;
   logic         in_ready;
   logic         op_sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         carry_out;
   logic         overflow;
   logic         zero;
   logic         negative;

   modport master (
      output in_valid, op_sub, a, b, out_ready,
      input  in_ready, out_valid, result, carry_out, overflow, zero, negative
   );

   modport slave (
      input  in_valid, op_sub, a, b, out_ready,
      output in_ready, out_valid, result, carry_out, overflow, zero, negative
   );

endinterface

// File: rtl/nibble_serial_add_sub_cell.sv
// Combinational 4-bit ripple slice; exposes the carry into the MSB so the
// last slice can derive signed overflow.
module nibble_add_cell
   import addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] a4,
   input  logic [NIBBLE_W-1:0] b4,
   input  logic                invert,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] s4,
   output logic                c3,
   output logic                c4
);

   logic [NIBBLE_W-1:0] bx;
   logic [NIBBLE_W-1:0] lo;
   logic [1:0]          hi;

   assign bx = b4 ^ {NIBBLE_W{invert}};

   // Low bits and MSB are summed separately so the MSB carry-in is visible.
   assign lo = {1'b0, a4[NIBBLE_W-2:0]} + {1'b0, bx[NIBBLE_W-2:0]}
             + {{(NIBBLE_W-1){1'b0}}, cin};
   assign hi = {1'b0, a4[NIBBLE_W-1]} + {1'b0, bx[NIBBLE_W-1]}
             + {1'b0, lo[NIBBLE_W-1]};

   assign s4 = {hi[0], lo[NIBBLE_W-2:0]};
   assign c3 = lo[NIBBLE_W-1];
   assign c4 = hi[1];

endmodule

// File: rtl/nibble_serial_add_sub.sv
// Nibble-serial two's-complement add/subtract, one slice per clock.
// Define ADDSUB_SAT_EN to clamp overflowing results to the signed limits.
module nibble_serial_add_sub
   import addsub_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   nibble_serial_add_sub_if.slave   bus
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   state_t            state_q, state_d;
   logic [W-1:0]      a_q, a_d;
   logic [W-1:0]      b_q, b_d;
   logic              op_q, op_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              zacc_q, zacc_d;
   logic [W-1:0]      result_q, result_d;
   flag_t             flags_q, flags_d;

   logic [NIBBLE_W-1:0] a_nib, b_nib, s_nib;
   logic                c3, c4, ovf, zacc_nxt;

`ifdef ADDSUB_SAT_EN
   function automatic logic signed [W-1:0] sat_clamp(input logic sign_a);
      logic signed [W-1:0] lim;
      lim = sign_a ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
      return lim;
   endfunction
`endif

   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int k = 0; k < NIBBLES; k++) begin
         if (idx_q == IDX_W'(k)) begin
            a_nib = a_q[k*NIBBLE_W +: NIBBLE_W];
            b_nib = b_q[k*NIBBLE_W +: NIBBLE_W];
         end
      end
   end

   nibble_add_cell u_cell (
      .a4     (a_nib),
      .b4     (b_nib),
      .invert (op_q),
      .cin    (carry_q),
      .s4     (s_nib),
      .c3     (c3),
      .c4     (c4)
   );

   assign ovf      = c3 ^ c4;
   assign zacc_nxt = zacc_q & (s_nib == '0);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      zacc_d   = zacc_q;
      result_d = result_q;
      flags_d  = flags_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               a_d     = bus.a;
               b_d     = bus.b;
               op_d    = bus.op_sub;
               carry_d = bus.op_sub;
               idx_d   = '0;
               zacc_d  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int k = 0; k < NIBBLES; k++) begin
               if (idx_q == IDX_W'(k)) result_d[k*NIBBLE_W +: NIBBLE_W] = s_nib;
            end
            carry_d = c4;
            zacc_d  = zacc_nxt;
            idx_d   = idx_q + IDX_W'(1);
            if (idx_q == LAST_IDX) begin
               idx_d     = '0;
               flags_d.c = c4;
               flags_d.v = ovf;
               flags_d.z = zacc_nxt;
`ifdef ADDSUB_SAT_EN
               // A clamped value is never zero.
               if (ovf) begin
                  result_d  = sat_clamp(a_q[W-1]);
                  flags_d.z = 1'b0;
               end
`endif
               flags_d.n = result_d[W-1];
               state_d   = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         zacc_q   <= 1'b0;
         result_q <= '0;
         flags_q  <= '0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         zacc_q   <= zacc_d;
         result_q <= result_d;
         flags_q  <= flags_d;
      end
   end

   // Operand latches only matter once RUN is entered, so they carry no reset.
   always_ff @(posedge clk) begin
      a_q  <= a_d;
      b_q  <= b_d;
      op_q <= op_d;
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.result    = result_q;
   assign bus.carry_out = flags_q.c;
   assign bus.overflow  = flags_q.v;
   assign bus.zero      = flags_q.z;
   assign bus.negative  = flags_q.n;

endmodule
